// File: rtl/soc_mem_pkg.sv
// Shared types for the code/data RAM arbiter: bus ownership and the response tag
// that travels alongside each access through the fixed memory read latency.
package soc_mem_pkg;

  typedef enum logic {
    OWNER_DATA  = 1'b0,
    OWNER_INSTR = 1'b1
  } bus_owner_t;

  typedef struct packed {
    logic       valid;
    bus_owner_t owner;
    logic       err;
    logic       we;
  } rsp_tag_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/rsp_tag_pipe.sv
// Response tag delay line, DEPTH cycles from tag_in to tag_out; never stalls.
// Reset clears every stage so in-flight accesses produce no response.
module rsp_tag_pipe
  import soc_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t stage_q [DEPTH];
  rsp_tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/ram_bus_arbiter.sv
// Round-robin share of one single-port SRAM between Ibex data and instr buses.
// Same-cycle grant, one access per cycle; response MEM_LATENCY cycles after gnt.
module ram_bus_arbiter
  import soc_mem_pkg::*;
#(
  parameter int  MEM_SIZE    = 16384,
  parameter int  MEM_LATENCY = 1,
  localparam int ADDR_W      = $clog2(MEM_SIZE) - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_req,
  output logic              data_gnt,
  input  logic [31:0]       data_addr,
  input  logic              data_we,
  input  logic [3:0]        data_be,
  input  logic [31:0]       data_wdata,
  output logic              data_rvalid,
  output logic [31:0]       data_rdata,
  output logic              data_err,
  input  logic              instr_req,
  output logic              instr_gnt,
  input  logic [31:0]       instr_addr,
  output logic              instr_rvalid,
  output logic [31:0]       instr_rdata,
  output logic              instr_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int OFS = $clog2(WORD_BYTES);

  bus_owner_t last_owner_q, last_owner_d;
  rsp_tag_t   tag_in, tag_out;
  logic       data_oor, instr_oor;
  logic [31:0] rsp_rdata;
  logic       unused_addr_lsbs;

  assign unused_addr_lsbs = ^{data_addr[OFS-1:0], instr_addr[OFS-1:0]};

  // Anything above the macro's word range is granted but answered with err.
  assign data_oor  = |data_addr[31:ADDR_W+OFS];
  assign instr_oor = |instr_addr[31:ADDR_W+OFS];

  always_comb begin
    data_gnt     = rst_n & data_req & (~instr_req | (last_owner_q == OWNER_INSTR));
    instr_gnt    = rst_n & instr_req & ~data_gnt;
    last_owner_d = last_owner_q;
    tag_in       = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'h0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (data_gnt) begin
      last_owner_d = OWNER_DATA;
      tag_in       = '{valid: 1'b1, owner: OWNER_DATA, err: data_oor, we: data_we};
      if (!data_oor) begin
        mem_req   = 1'b1;
        mem_we    = data_we;
        mem_be    = data_be;
        mem_addr  = data_addr[ADDR_W+OFS-1:OFS];
        mem_wdata = data_wdata;
      end
    end else if (instr_gnt) begin
      last_owner_d = OWNER_INSTR;
      tag_in       = '{valid: 1'b1, owner: OWNER_INSTR, err: instr_oor, we: 1'b0};
      if (!instr_oor) begin
        mem_req  = 1'b1;
        mem_be   = 4'hF;
        mem_addr = instr_addr[ADDR_W+OFS-1:OFS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWNER_INSTR;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

  rsp_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_rsp_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Writes and errored accesses return zero data rather than whatever the macro drives.
  always_comb begin
    rsp_rdata    = (tag_out.err | tag_out.we) ? 32'h0 : mem_rdata;
    data_rvalid  = tag_out.valid & (tag_out.owner == OWNER_DATA);
    instr_rvalid = tag_out.valid & (tag_out.owner == OWNER_INSTR);
    data_rdata   = data_rvalid  ? rsp_rdata : 32'h0;
    instr_rdata  = instr_rvalid ? rsp_rdata : 32'h0;
    data_err     = data_rvalid  & tag_out.err;
    instr_err    = instr_rvalid & tag_out.err;
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench: latency-1 and latency-3 arbiters, each with its own SRAM model
// preloaded so word i reads back 32'hC0DE0000 | i.
module tb_ram_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Latency-1 instance (a_*)
  logic        a_dreq, a_dgnt, a_dwe, a_drvalid, a_derr;
  logic [31:0] a_daddr, a_dwdata, a_drdata;
  logic [3:0]  a_dbe;
  logic        a_ireq, a_ignt, a_irvalid, a_ierr;
  logic [31:0] a_iaddr, a_irdata;
  logic        a_mreq, a_mwe;
  logic [3:0]  a_mbe;
  logic [11:0] a_maddr;
  logic [31:0] a_mwdata, a_mrdata;

  // Latency-3 instance (b_*)
  logic        b_dreq, b_dgnt, b_dwe, b_drvalid, b_derr;
  logic [31:0] b_daddr, b_dwdata, b_drdata;
  logic [3:0]  b_dbe;
  logic        b_ireq, b_ignt, b_irvalid, b_ierr;
  logic [31:0] b_iaddr, b_irdata;
  logic        b_mreq, b_mwe;
  logic [3:0]  b_mbe;
  logic [11:0] b_maddr;
  logic [31:0] b_mwdata, b_mrdata;

  ram_bus_arbiter #(.MEM_SIZE(16384), .MEM_LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .data_req(a_dreq), .data_gnt(a_dgnt), .data_addr(a_daddr), .data_we(a_dwe),
    .data_be(a_dbe), .data_wdata(a_dwdata), .data_rvalid(a_drvalid),
    .data_rdata(a_drdata), .data_err(a_derr),
    .instr_req(a_ireq), .instr_gnt(a_ignt), .instr_addr(a_iaddr),
    .instr_rvalid(a_irvalid), .instr_rdata(a_irdata), .instr_err(a_ierr),
    .mem_req(a_mreq), .mem_we(a_mwe), .mem_be(a_mbe), .mem_addr(a_maddr),
    .mem_wdata(a_mwdata), .mem_rdata(a_mrdata)
  );

  ram_bus_arbiter #(.MEM_SIZE(16384), .MEM_LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .data_req(b_dreq), .data_gnt(b_dgnt), .data_addr(b_daddr), .data_we(b_dwe),
    .data_be(b_dbe), .data_wdata(b_dwdata), .data_rvalid(b_drvalid),
    .data_rdata(b_drdata), .data_err(b_derr),
    .instr_req(b_ireq), .instr_gnt(b_ignt), .instr_addr(b_iaddr),
    .instr_rvalid(b_irvalid), .instr_rdata(b_irdata), .instr_err(b_ierr),
    .mem_req(b_mreq), .mem_we(b_mwe), .mem_be(b_mbe), .mem_addr(b_maddr),
    .mem_wdata(b_mwdata), .mem_rdata(b_mrdata)
  );

  logic [31:0] mem_a [4096];
  logic [31:0] mem_b [4096];
  logic [31:0] a_rd;
  logic [31:0] b_p0, b_p1, b_p2;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 4096; i++) mem_a[i] <= 32'hC0DE0000 | 32'(i);
    end else if (a_mreq) begin
      a_rd <= mem_a[a_maddr];
      if (a_mwe)
        for (int j = 0; j < 4; j++)
          if (a_mbe[j]) mem_a[a_maddr][8*j +: 8] <= a_mwdata[8*j +: 8];
    end
  end
  assign a_mrdata = a_rd;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 4096; i++) mem_b[i] <= 32'hC0DE0000 | 32'(i);
    end else if (b_mreq) begin
      b_p0 <= mem_b[b_maddr];
      if (b_mwe)
        for (int j = 0; j < 4; j++)
          if (b_mbe[j]) mem_b[b_maddr][8*j +: 8] <= b_mwdata[8*j +: 8];
    end
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_mrdata = b_p2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_dreq = 0; a_dwe = 0; a_dbe = 4'h0; a_daddr = '0; a_dwdata = '0;
    a_ireq = 0; a_iaddr = '0;
  endtask

  task automatic b_idle();
    b_dreq = 0; b_dwe = 0; b_dbe = 4'h0; b_daddr = '0; b_dwdata = '0;
    b_ireq = 0; b_iaddr = '0;
  endtask

  task automatic a_data(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata);
    a_dreq = 1; a_dwe = we; a_daddr = addr; a_dbe = be; a_dwdata = wdata;
  endtask

  initial begin
    a_idle();
    b_idle();
    a_dreq = 1;
    repeat (3) next_cyc();
    #3;
    check_eq("rst_mem_req", a_mreq, 1'b0);
    check_eq("rst_d_rvalid", a_drvalid, 1'b0);
    check_eq("rst_d_rdata", a_drdata, 32'h0);
    check_eq("rst_d_err", a_derr, 1'b0);
    check_eq("rst_i_rvalid", a_irvalid, 1'b0);
    check_eq("rst_b_rvalid", b_drvalid | b_irvalid, 1'b0);
    next_cyc();

    // Both buses requesting from the first cycle out of reset: data wins first.
    rst_n = 1; load = 0;
    for (int k = 0; k < 5; k++) begin
      a_dreq = (k < 4); a_daddr = 32'h100; a_dwe = 0;
      a_ireq = (k < 4); a_iaddr = 32'h200;
      #3;
      check_eq($sformatf("pp_dgnt%0d", k), a_dgnt, (k < 4) && (k % 2 == 0));
      check_eq($sformatf("pp_ignt%0d", k), a_ignt, (k < 4) && (k % 2 == 1));
      check_eq($sformatf("pp_mreq%0d", k), a_mreq, (k < 4));
      check_eq($sformatf("pp_drv%0d", k), a_drvalid, (k >= 1) && ((k - 1) % 2 == 0));
      check_eq($sformatf("pp_irv%0d", k), a_irvalid, (k >= 1) && ((k - 1) % 2 == 1));
      if (k < 4 && k % 2 == 1) check_eq("pp_iaddr", a_maddr, 12'h080);
      if (k < 4 && k % 2 == 1) check_eq("pp_ibe", a_mbe, 4'hF);
      if ((k >= 1) && ((k - 1) % 2 == 0)) check_eq("pp_drdata", a_drdata, 32'hC0DE0040);
      if ((k >= 1) && ((k - 1) % 2 == 1)) check_eq("pp_irdata", a_irdata, 32'hC0DE0080);
      next_cyc();
    end
    a_idle();

    // Full-word write then read back.
    a_data(1, 32'h10, 4'hF, 32'hDEADBEEF);
    #3;
    check_eq("wr_gnt", a_dgnt, 1'b1);
    check_eq("wr_mwe", a_mwe, 1'b1);
    check_eq("wr_maddr", a_maddr, 12'h004);
    check_eq("wr_wdata", a_mwdata, 32'hDEADBEEF);
    next_cyc();
    a_data(0, 32'h10, 4'hF, 32'h0);
    #3;
    check_eq("wr_rsp_rvalid", a_drvalid, 1'b1);
    check_eq("wr_rsp_rdata", a_drdata, 32'h0);
    check_eq("rd_mwe", a_mwe, 1'b0);
    next_cyc();
    a_idle();
    #3;
    check_eq("rd_rvalid", a_drvalid, 1'b1);
    check_eq("rd_rdata", a_drdata, 32'hDEADBEEF);
    check_eq("rd_err", a_derr, 1'b0);
    check_eq("rd_i_rvalid", a_irvalid, 1'b0);
    next_cyc();
    #3;
    check_eq("rd_one_pulse", a_drvalid, 1'b0);
    next_cyc();

    // Byte-lane merge.
    a_data(1, 32'h20, 4'hF, 32'h11223344);
    next_cyc();
    a_data(1, 32'h20, 4'b0100, 32'h00AA0000);
    #3;
    check_eq("bw_mbe", a_mbe, 4'b0100);
    next_cyc();
    a_data(0, 32'h20, 4'hF, 32'h0);
    next_cyc();
    a_idle();
    #3;
    check_eq("bw_rdata", a_drdata, 32'h11AA3344);
    next_cyc();

    // Out-of-range fetch followed by a normal one.
    a_ireq = 1; a_iaddr = 32'h4000;
    #3;
    check_eq("oor_gnt", a_ignt, 1'b1);
    check_eq("oor_mreq", a_mreq, 1'b0);
    next_cyc();
    a_iaddr = 32'h40;
    #3;
    check_eq("oor_rvalid", a_irvalid, 1'b1);
    check_eq("oor_err", a_ierr, 1'b1);
    check_eq("oor_rdata", a_irdata, 32'h0);
    check_eq("oor_next_mreq", a_mreq, 1'b1);
    check_eq("oor_next_maddr", a_maddr, 12'h010);
    next_cyc();
    a_idle();
    #3;
    check_eq("oor_next_rvalid", a_irvalid, 1'b1);
    check_eq("oor_next_err", a_ierr, 1'b0);
    check_eq("oor_next_rdata", a_irdata, 32'hC0DE0010);
    check_eq("oor_d_rvalid", a_drvalid, 1'b0);
    next_cyc();

    // Latency 3: back-to-back reads at 0x0, 0x4, 0x8.
    for (int k = 0; k < 7; k++) begin
      b_dreq = (k < 3); b_dwe = 0; b_daddr = 32'(4 * k);
      #3;
      check_eq($sformatf("l3_gnt%0d", k), b_dgnt, (k < 3));
      check_eq($sformatf("l3_rvalid%0d", k), b_drvalid, (k >= 3) && (k <= 5));
      if (k >= 3 && k <= 5)
        check_eq($sformatf("l3_rdata%0d", k), b_drdata, 32'hC0DE0000 + 32'(k - 3));
      next_cyc();
    end
    b_idle();

    // Reset while a read is in flight.
    b_dreq = 1; b_daddr = 32'hC;
    #3;
    check_eq("mid_gnt", b_dgnt, 1'b1);
    next_cyc();
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      #3;
      check_eq($sformatf("mid_rst_mreq%0d", k), b_mreq, 1'b0);
      next_cyc();
    end
    rst_n = 1; b_idle();
    for (int k = 0; k < 4; k++) begin
      #3;
      check_eq($sformatf("mid_no_rvalid%0d", k), b_drvalid | b_irvalid, 1'b0);
      next_cyc();
    end
    b_dreq = 1; b_daddr = 32'h0; b_ireq = 1; b_iaddr = 32'h4;
    #3;
    check_eq("mid_conf_dgnt", b_dgnt, 1'b1);
    check_eq("mid_conf_ignt", b_ignt, 1'b0);
    next_cyc();
    #3;
    check_eq("mid_conf2_ignt", b_ignt, 1'b1);
    next_cyc();
    b_idle();
    repeat (4) next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares one single-port synchronous SRAM macro between the Ibex data bus and the Ibex instruction bus.
- Arbitrates requests round-robin and drives the flat memory port.
- Tracks which bus owns each response through the fixed memory read latency, and returns rvalid/rdata/err to that owner.
- Sits between the core bus interfaces and the code/data RAM instance; address decode into this slave is done upstream.

Parameters:
- MEM_SIZE, 16384, RAM size in bytes; power of two, minimum 64.
- MEM_LATENCY, 1, cycles from mem_req to valid mem_rdata; legal values 1..3.
- ADDR_W, log2(MEM_SIZE)-2, word address width; localparam, not overridable.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- data_bus  ibex_data_bus.slave  -  core data port (req, gnt, addr, we, be, wdata, rvalid, rdata, err)
- instr_bus  ibex_instr_bus.slave  -  core fetch port (req, gnt, addr, rvalid, rdata, err)
- mem_req  output  1  memory access strobe
- mem_we  output  1  write enable
- mem_be  output  4  byte enables
- mem_addr  output  ADDR_W  word address (bus addr[ADDR_W+1:2])
- mem_wdata  output  32  write data
- mem_rdata  input  32  read data, valid MEM_LATENCY cycles after mem_req

Behaviour:
- Clock and reset: single clock domain clk; rst_n asynchronous, active-low.
- Grant timing: gnt is combinational, in the same cycle as req. At most one gnt per cycle. No back-to-back stall is needed; the memory accepts one access per cycle.
- Arbitration pointer: 1-bit last_owner register.
  - Data request only: grant data.
  - Instr request only: grant instr.
  - Both requesting: grant the bus that was not granted most recently.
  - last_owner updates only on a grant.
  - Reset value: INSTR, so data wins the first conflict.
- Memory drive on a granted in-range access:
  - mem_req=1.
  - mem_addr comes from the granted bus.
  - For a data grant, mem_we/mem_be/mem_wdata come from data_bus.
  - For an instr grant: mem_we=0, mem_be=4'hF, mem_wdata=0.
  - With no grant, all mem_* outputs are 0.
- Out-of-range access (addr[31:2] >= MEM_SIZE/4 after masking the upstream base is NOT done here; the test is on addr[31:ADDR_W+2] != 0):
  - The access is still granted, but mem_req=0.
  - The response carries err=1 and rdata=0.
- Response tag pipeline: MEM_LATENCY stages, each holding {valid, owner, err}, shifted every cycle.
  - When the head is valid, the owner bus receives rvalid=1 for exactly one cycle.
  - rdata = mem_rdata (0 if the access was a write or an error); err from the tag.
  - The non-owner bus sees rvalid=0.
- Response registers: rvalid/rdata/err are driven combinationally from the pipeline head and mem_rdata, so response latency equals MEM_LATENCY cycles after gnt. Writes also return rvalid, because Ibex requires it.
- Throughput: one grant per cycle sustained with both requesting continuously (ping-pong pattern). Each bus receives responses in grant order.
- Reset values:
  - rvalid=0, err=0, rdata=0 on both buses.
  - All pipeline stages invalid; last_owner=INSTR.
  - While rst_n is low, mem_req=0 regardless of req.
- Reset mid-operation: in-flight tags are discarded and no rvalid is issued for them. The core is reset with the same rst_n.
- A req that stays high after gnt is a new request in the next cycle; there is no request holding.

Decomposition:
- Package soc_mem_pkg holds:
  - typedef enum logic {OWNER_DATA, OWNER_INSTR} bus_owner_t
  - typedef struct packed {logic valid; bus_owner_t owner; logic err; logic we;} rsp_tag_t
  - localparam WORD_BYTES=4
- Sub-module rsp_tag_pipe (parameter DEPTH=MEM_LATENCY): async-reset shift register of rsp_tag_t with in/out ports. The arbiter top holds the RR pointer, mux and response steering.

Test Plan:
- Data read only: write 0xDEADBEEF at addr 0x10 via data bus (be=4'hF), then read 0x10 -> gnt same cycle; rvalid exactly 1 cycle later (MEM_LATENCY=1); rdata=0xDEADBEEF, err=0; instr_bus.rvalid stays 0.
- Simultaneous requests for 4 cycles, first cycle after reset:
  - Grant order is data, instr, data, instr.
  - Each bus sees 2 rvalids, 1 cycle after its gnts.
  - mem_req is high all 4 cycles.
- Byte write: write 0x11223344 at 0x20, then write be=4'b0100 wdata=0x00AA0000, then read -> 0x11AA3344.
- Out-of-range: instr addr = MEM_SIZE (0x4000) -> gnt=1, mem_req=0; next cycle instr rvalid=1, err=1, rdata=0. The next in-range fetch is unaffected.
- Latency 3 build: back-to-back data reads at 0x0, 0x4, 0x8 -> rvalids on cycles 3, 4, 5 with the matching data in order.
- Reset mid-flight: MEM_LATENCY=3, grant a read, assert rst_n low the following cycle for 2 cycles -> no rvalid on either bus afterward. The first conflict after reset is granted to data.
